// File: rtl/ara_inval_arbiter.sv
// Merges cache-line invalidations from several coherence sources onto CVA6's single
// invalidation port. Each source has a small FIFO that coalesces duplicate lines at its tail.
module ara_inval_arbiter #(
   parameter int unsigned NrSources   = 2,
   parameter int unsigned AddrWidth   = 64,
   parameter int unsigned L1LineWidth = 16,
   parameter int unsigned FifoDepth   = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                en_i,
   input  logic [NrSources-1:0]                src_valid_i,
   input  logic [NrSources-1:0][AddrWidth-1:0] src_addr_i,
   output logic [NrSources-1:0]                src_ready_o,
   output logic                                inval_valid_o,
   output logic [AddrWidth-1:0]                inval_addr_o,
   input  logic                                inval_ready_i,
   output logic                                pending_o
);

   localparam int unsigned OffW  = $clog2(L1LineWidth);
   localparam int unsigned LineW = AddrWidth - OffW;
   localparam int unsigned PtrW  = $clog2(FifoDepth);
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned RrW   = (NrSources > 1) ? $clog2(NrSources) : 1;

   typedef logic [LineW-1:0] line_t;

   line_t           mem_q    [NrSources][FifoDepth];
   logic [PtrW-1:0] wr_ptr_q [NrSources];
   logic [PtrW-1:0] rd_ptr_q [NrSources];
   logic [CntW-1:0] count_q  [NrSources];
   logic [RrW-1:0]  rr_q;
   logic            out_valid_q;
   line_t           out_line_q;

   line_t          in_line   [NrSources];
   line_t          tail_line [NrSources];
   logic [NrSources-1:0] full;
   logic [NrSources-1:0] nonempty;
   logic [NrSources-1:0] coalesce;
   logic [NrSources-1:0] push;
   logic [NrSources-1:0] pop;
   logic           load;
   logic           grant_valid;
   logic [RrW-1:0] grant_idx;
   line_t          grant_line;

   // The tail compare uses the pre-pop tail: a line just popped into the output
   // register has not reached CVA6 yet, so dropping a duplicate of it is still safe.
   always_comb begin
      for (int unsigned i = 0; i < NrSources; i++) begin
         in_line[i]     = src_addr_i[i][AddrWidth-1:OffW];
         tail_line[i]   = mem_q[i][wr_ptr_q[i] - PtrW'(1)];
         full[i]        = (count_q[i] == CntW'(FifoDepth));
         nonempty[i]    = (count_q[i] != '0);
         src_ready_o[i] = !en_i || !full[i];
         coalesce[i]    = nonempty[i] && (in_line[i] == tail_line[i]);
         push[i]        = src_valid_i[i] && src_ready_o[i] && en_i && !coalesce[i];
      end
   end

   always_comb begin
      int unsigned idx;
      grant_valid = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      for (int unsigned k = 0; k < NrSources; k++) begin
         idx = (32'(rr_q) + k) % NrSources;
         if (!grant_valid && nonempty[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = RrW'(idx);
         end
      end
      grant_line = mem_q[grant_idx][rd_ptr_q[grant_idx]];
      load       = !out_valid_q || inval_ready_i;
      for (int unsigned i = 0; i < NrSources; i++) begin
         pop[i] = load && grant_valid && (grant_idx == RrW'(i));
      end
   end

   always_ff @(posedge clk_i) begin
      for (int unsigned i = 0; i < NrSources; i++) begin
         if (push[i]) begin
            mem_q[i][wr_ptr_q[i]] <= in_line[i];
         end
      end
   end

   // Buffered entries survive a falling en_i; only reset discards them.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NrSources; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            count_q[i]  <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NrSources; i++) begin
            if (push[i]) begin
               wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
            end
            if (pop[i]) begin
               rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
            end
            count_q[i] <= count_q[i] + CntW'(push[i]) - CntW'(pop[i]);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q <= 1'b0;
         out_line_q  <= '0;
         rr_q        <= '0;
      end else if (load) begin
         out_valid_q <= grant_valid;
         if (grant_valid) begin
            out_line_q <= grant_line;
            rr_q       <= (grant_idx == RrW'(NrSources - 1)) ? '0 : grant_idx + RrW'(1);
         end
      end
   end

   assign inval_valid_o = out_valid_q;
   assign inval_addr_o  = AddrWidth'(out_line_q) << OffW;
   assign pending_o     = out_valid_q || (|nonempty);

   // Byte-offset bits of the source addresses are intentionally ignored.
   if (OffW > 0) begin : g_offset
      logic offset_unused;
      always_comb begin
         offset_unused = 1'b0;
         for (int unsigned i = 0; i < NrSources; i++) begin
            offset_unused = offset_unused ^ (^src_addr_i[i][OffW-1:0]);
         end
      end
   end

endmodule

// File: tb/tb_ara_inval_arbiter.sv
// Directed bench for ara_inval_arbiter: latency, round-robin order, coalescing,
// backpressure/full, enable-off discard and asynchronous reset mid-drain.
module tb_ara_inval_arbiter;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             en;
   logic [1:0]       src_valid;
   logic [1:0][63:0] src_addr;
   logic [1:0]       src_ready;
   logic             inval_valid;
   logic [63:0]      inval_addr;
   logic             inval_ready;
   logic             pending;

   int checks = 0;
   int errors = 0;

   ara_inval_arbiter #(
      .NrSources(2), .AddrWidth(64), .L1LineWidth(16), .FifoDepth(4)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .en_i(en),
      .src_valid_i(src_valid),
      .src_addr_i(src_addr),
      .src_ready_o(src_ready),
      .inval_valid_o(inval_valid),
      .inval_addr_o(inval_addr),
      .inval_ready_i(inval_ready),
      .pending_o(pending)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] v, input logic [63:0] a0, input logic [63:0] a1);
      src_valid   = v;
      src_addr[0] = a0;
      src_addr[1] = a1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic doReset(input string tag);
      applyStimulus(2'b00, 64'h0, 64'h0);
      rst_n = 1'b0;
      #1;
      checkOutput({tag, "_rst_valid"}, 64'(inval_valid), 64'h0);
      checkOutput({tag, "_rst_addr"}, inval_addr, 64'h0);
      checkOutput({tag, "_rst_pending"}, 64'(pending), 64'h0);
      checkOutput({tag, "_rst_ready"}, 64'(src_ready), 64'h3);
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [63:0] rr_exp [4];
      en          = 1'b1;
      inval_ready = 1'b1;
      applyStimulus(2'b00, 64'h0, 64'h0);
      #2;

      // Single request: two-cycle latency, line-aligned, one cycle valid
      $display("[TB] single request");
      doReset("t1");
      applyStimulus(2'b01, 64'h8000_0044, 64'h0);
      tick();
      applyStimulus(2'b00, 64'h0, 64'h0);
      checkOutput("t1_valid_early", 64'(inval_valid), 64'h0);
      checkOutput("t1_pending_fifo", 64'(pending), 64'h1);
      tick();
      checkOutput("t1_valid", 64'(inval_valid), 64'h1);
      checkOutput("t1_addr", inval_addr, 64'h8000_0040);
      tick();
      checkOutput("t1_valid_done", 64'(inval_valid), 64'h0);
      checkOutput("t1_pending_done", 64'(pending), 64'h0);

      // Round-robin across two sources
      $display("[TB] round robin");
      doReset("t2");
      applyStimulus(2'b11, 64'h1000, 64'h2000);
      tick();
      applyStimulus(2'b11, 64'h1010, 64'h2010);
      tick();
      checkOutput("t2_v0", 64'(inval_valid), 64'h1);
      checkOutput("t2_a0", inval_addr, 64'h1000);
      applyStimulus(2'b11, 64'h1020, 64'h2020);
      tick();
      checkOutput("t2_a1", inval_addr, 64'h2000);
      checkOutput("t2_ready", 64'(src_ready), 64'h3);
      applyStimulus(2'b00, 64'h0, 64'h0);
      rr_exp = '{64'h1010, 64'h2010, 64'h1020, 64'h2020};
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput($sformatf("t2_v%0d", i + 2), 64'(inval_valid), 64'h1);
         checkOutput($sformatf("t2_a%0d", i + 2), inval_addr, rr_exp[i]);
      end
      tick();
      checkOutput("t2_valid_done", 64'(inval_valid), 64'h0);

      // Coalescing of consecutive duplicates at the tail, output register held
      $display("[TB] coalesce");
      doReset("t3");
      inval_ready = 1'b0;
      applyStimulus(2'b01, 64'h5000, 64'h0);
      tick();
      applyStimulus(2'b00, 64'h0, 64'h0);
      tick();
      checkOutput("t3_hold_addr", inval_addr, 64'h5000);
      applyStimulus(2'b10, 64'h0, 64'h3004);
      tick();
      applyStimulus(2'b10, 64'h0, 64'h3008);
      tick();
      applyStimulus(2'b10, 64'h0, 64'h300C);
      tick();
      applyStimulus(2'b00, 64'h0, 64'h0);
      checkOutput("t3_held_valid", 64'(inval_valid), 64'h1);
      checkOutput("t3_held_addr", inval_addr, 64'h5000);
      inval_ready = 1'b1;
      tick();
      checkOutput("t3_coal_addr", inval_addr, 64'h3000);
      tick();
      checkOutput("t3_coal_once", 64'(inval_valid), 64'h0);
      checkOutput("t3_coal_pending", 64'(pending), 64'h0);
      inval_ready = 1'b0;
      applyStimulus(2'b01, 64'h5010, 64'h0);
      tick();
      applyStimulus(2'b00, 64'h0, 64'h0);
      tick();
      applyStimulus(2'b10, 64'h0, 64'h3000);
      tick();
      applyStimulus(2'b10, 64'h0, 64'h3010);
      tick();
      applyStimulus(2'b10, 64'h0, 64'h3000);
      tick();
      applyStimulus(2'b00, 64'h0, 64'h0);
      checkOutput("t3_b_held", inval_addr, 64'h5010);
      inval_ready = 1'b1;
      tick();
      checkOutput("t3_b_a0", inval_addr, 64'h3000);
      tick();
      checkOutput("t3_b_a1", inval_addr, 64'h3010);
      tick();
      checkOutput("t3_b_a2", inval_addr, 64'h3000);
      checkOutput("t3_b_v2", 64'(inval_valid), 64'h1);
      tick();
      checkOutput("t3_b_done", 64'(inval_valid), 64'h0);

      // Backpressure until the FIFO is full, then drain in order
      $display("[TB] backpressure and full");
      doReset("t4");
      inval_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(2'b01, 64'h4000 + 64'(16 * k), 64'h0);
         tick();
      end
      applyStimulus(2'b01, 64'h4050, 64'h0);
      #1;
      checkOutput("t4_full_ready", 64'(src_ready), 64'h2);
      tick();
      checkOutput("t4_full_ready2", 64'(src_ready), 64'h2);
      applyStimulus(2'b00, 64'h0, 64'h0);
      en = 1'b0;
      #1;
      checkOutput("t4_dis_ready", 64'(src_ready), 64'h3);
      en = 1'b1;
      #1;
      checkOutput("t4_en_ready", 64'(src_ready), 64'h2);
      checkOutput("t4_head", inval_addr, 64'h4000);
      inval_ready = 1'b1;
      tick();
      checkOutput("t4_a1", inval_addr, 64'h4010);
      checkOutput("t4_ready_back", 64'(src_ready), 64'h3);
      tick();
      checkOutput("t4_a2", inval_addr, 64'h4020);
      tick();
      checkOutput("t4_a3", inval_addr, 64'h4030);
      tick();
      checkOutput("t4_a4", inval_addr, 64'h4040);
      checkOutput("t4_v4", 64'(inval_valid), 64'h1);
      tick();
      checkOutput("t4_done", 64'(inval_valid), 64'h0);
      checkOutput("t4_pending", 64'(pending), 64'h0);

      // Disable: new requests accepted and dropped, buffered ones drain
      $display("[TB] enable off");
      doReset("t5");
      inval_ready = 1'b0;
      applyStimulus(2'b01, 64'h6000, 64'h0);
      tick();
      applyStimulus(2'b00, 64'h0, 64'h0);
      tick();
      applyStimulus(2'b10, 64'h0, 64'h7000);
      tick();
      en = 1'b0;
      applyStimulus(2'b11, 64'h6100, 64'h7100);
      #1;
      checkOutput("t5_ready", 64'(src_ready), 64'h3);
      tick();
      applyStimulus(2'b11, 64'h6200, 64'h7200);
      tick();
      applyStimulus(2'b00, 64'h0, 64'h0);
      checkOutput("t5_pending", 64'(pending), 64'h1);
      checkOutput("t5_a0", inval_addr, 64'h6000);
      inval_ready = 1'b1;
      tick();
      checkOutput("t5_a1", inval_addr, 64'h7000);
      checkOutput("t5_v1", 64'(inval_valid), 64'h1);
      tick();
      checkOutput("t5_done", 64'(inval_valid), 64'h0);
      checkOutput("t5_pending_done", 64'(pending), 64'h0);
      en = 1'b1;

      // Asynchronous reset in the middle of a drain
      $display("[TB] reset mid-drain");
      doReset("t6");
      applyStimulus(2'b11, 64'h9000, 64'h9100);
      tick();
      applyStimulus(2'b11, 64'h9010, 64'h9110);
      tick();
      applyStimulus(2'b00, 64'h0, 64'h0);
      tick();
      checkOutput("t6_pre_addr", inval_addr, 64'h9100);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_async_valid", 64'(inval_valid), 64'h0);
      checkOutput("t6_async_pending", 64'(pending), 64'h0);
      checkOutput("t6_async_addr", inval_addr, 64'h0);
      tick();
      rst_n = 1'b1;
      applyStimulus(2'b11, 64'hA000, 64'hA100);
      tick();
      applyStimulus(2'b00, 64'h0, 64'h0);
      tick();
      checkOutput("t6_first_addr", inval_addr, 64'hA000);
      tick();
      checkOutput("t6_second_addr", inval_addr, 64'hA100);
      tick();
      checkOutput("t6_done", 64'(inval_valid), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
